// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared constants and types for the falling-piece sequencer
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int SPAWN_X = 3;
   localparam int SPAWN_Y = 0;

   localparam logic [1:0] OP_LEFT  = 2'd0;
   localparam logic [1:0] OP_RIGHT = 2'd1;
   localparam logic [1:0] OP_ROT   = 2'd2;
   localparam logic [1:0] OP_DOWN  = 2'd3;

   localparam logic [2:0] SHAPE_O = 3'd0;
   localparam logic [2:0] SHAPE_I = 3'd1;
   localparam logic [2:0] SHAPE_J = 3'd2;
   localparam logic [2:0] SHAPE_L = 3'd3;
   localparam logic [2:0] SHAPE_S = 3'd4;
   localparam logic [2:0] SHAPE_T = 3'd5;
   localparam logic [2:0] SHAPE_Z = 3'd6;

   typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_e;

endpackage

// File: rtl/tetris_piece_offsets.sv
// rtl/tetris_piece_offsets.sv - cell offsets of each tetromino shape and rotation
// Cell k occupies dx[2k+1:2k], dy[2k+1:2k] relative to the pose origin.
module tetris_piece_offsets (
   input  logic [2:0] shape,
   input  logic [1:0] rot,
   output logic [7:0] dx,
   output logic [7:0] dy
);
   import tetris_pkg::*;

   // four {dx,dy} nibbles, cell 0 in the top nibble
   logic [15:0] cells;

   always_comb begin
      cells = 16'h0000;
      case (shape)
         SHAPE_O: cells = 16'h596A;
         SHAPE_I: cells = rot[0] ? 16'h048C : 16'h0123;
         SHAPE_J: begin
            case (rot)
               2'd0:    cells = 16'h0159;
               2'd1:    cells = 16'h4856;
               2'd2:    cells = 16'h159A;
               default: cells = 16'h4526;
            endcase
         end
         SHAPE_L: begin
            case (rot)
               2'd0:    cells = 16'h8159;
               2'd1:    cells = 16'h456A;
               2'd2:    cells = 16'h1592;
               default: cells = 16'h0456;
            endcase
         end
         SHAPE_S: cells = rot[0] ? 16'h459A : 16'h4815;
         SHAPE_T: begin
            case (rot)
               2'd0:    cells = 16'h4159;
               2'd1:    cells = 16'h4596;
               2'd2:    cells = 16'h1596;
               default: cells = 16'h4156;
            endcase
         end
         SHAPE_Z: cells = rot[0] ? 16'h8596 : 16'h0459;
         default: cells = 16'h0000;
      endcase

      dx = 8'h00;
      dy = 8'h00;
      for (int k = 0; k < 4; k++) begin
         dx[2*k +: 2] = cells[15-4*k -: 2];
         dy[2*k +: 2] = cells[13-4*k -: 2];
      end
   end

endmodule

// File: rtl/tetris_piece_controller.sv
// rtl/tetris_piece_controller.sv - active-piece sequencer: spawn/move/rotate/drop with board collision probe
// Each request expands the candidate pose to four cells and probes them over a one-cycle board read port.
module tetris_piece_controller #(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H,
   parameter int SPAWN_X = tetris_pkg::SPAWN_X,
   parameter int SPAWN_Y = tetris_pkg::SPAWN_Y
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       spawn_valid,
   input  logic [2:0] spawn_shape,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   output logic       cmd_ready,
   output logic       rd_en,
   output logic [3:0] rd_x,
   output logic [4:0] rd_y,
   input  logic       rd_occ,
   output logic       piece_valid,
   output logic [3:0] piece_x,
   output logic [4:0] piece_y,
   output logic [1:0] piece_rot,
   output logic [2:0] piece_shape,
   output logic       done,
   output logic       blocked,
   output logic       lock,
   output logic       game_over
);
   import tetris_pkg::*;

   localparam logic signed [5:0] W_LIM = 6'(BOARD_W);
   localparam logic signed [5:0] H_LIM = 6'(BOARD_H);
   localparam logic signed [5:0] SP_X  = 6'(SPAWN_X);
   localparam logic signed [5:0] SP_Y  = 6'(SPAWN_Y);

   state_e            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic signed [5:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
   logic [1:0]        cand_rot_q, cand_rot_d;
   logic [2:0]        cand_shape_q, cand_shape_d;
   logic              is_spawn_q, is_spawn_d, is_down_q, is_down_d;
   logic              inv_q, inv_d, blk_q, blk_d, pend_q, pend_d;
   logic              cmd_ready_q, cmd_ready_d, rd_en_q, rd_en_d;
   logic [3:0]        rd_x_q, rd_x_d;
   logic [4:0]        rd_y_q, rd_y_d;
   logic              piece_valid_q, piece_valid_d;
   logic [3:0]        piece_x_q, piece_x_d;
   logic [4:0]        piece_y_q, piece_y_d;
   logic [1:0]        piece_rot_q, piece_rot_d;
   logic [2:0]        piece_shape_q, piece_shape_d;
   logic              done_q, done_d, blocked_q, blocked_d;
   logic              lock_q, lock_d, game_over_q, game_over_d;

   logic [7:0]        off_dx, off_dy;
   logic              accept, probe, oob, fail;
   logic [1:0]        sel;
   logic signed [5:0] cell_x, cell_y;

   // fed by the next candidate so the first cell can be addressed at accept
   tetris_piece_offsets u_offsets (
      .shape (cand_shape_d),
      .rot   (cand_rot_d),
      .dx    (off_dx),
      .dy    (off_dy)
   );

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      cand_x_d      = cand_x_q;
      cand_y_d      = cand_y_q;
      cand_rot_d    = cand_rot_q;
      cand_shape_d  = cand_shape_q;
      is_spawn_d    = is_spawn_q;
      is_down_d     = is_down_q;
      inv_d         = inv_q;
      piece_valid_d = piece_valid_q;
      piece_x_d     = piece_x_q;
      piece_y_d     = piece_y_q;
      piece_rot_d   = piece_rot_q;
      piece_shape_d = piece_shape_q;
      game_over_d   = game_over_q;
      done_d        = 1'b0;
      blocked_d     = 1'b0;
      lock_d        = 1'b0;
      accept        = 1'b0;
      probe         = 1'b0;
      sel           = 2'd0;
      fail          = blk_q | (pend_q & rd_occ) | inv_q;

      case (state_q)
         IDLE: begin
            if (cmd_ready_q && (spawn_valid || cmd_valid)) begin
               accept  = 1'b1;
               probe   = 1'b1;
               state_d = CHECK;
               k_d     = 2'd0;
               if (spawn_valid) begin
                  cand_x_d     = SP_X;
                  cand_y_d     = SP_Y;
                  cand_rot_d   = 2'd0;
                  cand_shape_d = spawn_shape;
                  is_spawn_d   = 1'b1;
                  is_down_d    = 1'b0;
                  inv_d        = (spawn_shape == 3'd7);
               end else begin
                  cand_x_d     = $signed({2'b00, piece_x_q});
                  cand_y_d     = $signed({1'b0, piece_y_q});
                  cand_rot_d   = piece_rot_q;
                  cand_shape_d = piece_shape_q;
                  is_spawn_d   = 1'b0;
                  is_down_d    = (cmd_op == OP_DOWN);
                  inv_d        = ~piece_valid_q;
                  case (cmd_op)
                     OP_LEFT:  cand_x_d   = cand_x_d - 6'sd1;
                     OP_RIGHT: cand_x_d   = cand_x_d + 6'sd1;
                     OP_ROT:   cand_rot_d = piece_rot_q + 2'd1;
                     default:  cand_y_d   = cand_y_d + 6'sd1;
                  endcase
               end
            end
         end
         CHECK: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = WAIT;
            end else begin
               probe = 1'b1;
               sel   = k_q + 2'd1;
            end
         end
         WAIT: begin
            state_d   = RESP;
            done_d    = 1'b1;
            blocked_d = fail;
            if (!fail) begin
               piece_valid_d = 1'b1;
               piece_x_d     = cand_x_q[3:0];
               piece_y_d     = cand_y_q[4:0];
               piece_rot_d   = cand_rot_q;
               piece_shape_d = cand_shape_q;
            end else if (!inv_q) begin
               if (is_spawn_q) begin
                  game_over_d   = 1'b1;
                  piece_valid_d = 1'b0;
               end else if (is_down_q) begin
                  lock_d        = 1'b1;
                  piece_valid_d = 1'b0;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE) && !game_over_d;
   end

   // out-of-bounds cells are blocked without a board read
   always_comb begin
      cell_x  = cand_x_d + $signed({4'b0000, off_dx[{sel, 1'b0} +: 2]});
      cell_y  = cand_y_d + $signed({4'b0000, off_dy[{sel, 1'b0} +: 2]});
      oob     = (cell_x < 6'sd0) || (cell_x >= W_LIM) || (cell_y >= H_LIM);
      rd_en_d = probe && !oob && !inv_d;
      rd_x_d  = rd_en_d ? cell_x[3:0] : 4'd0;
      rd_y_d  = rd_en_d ? cell_y[4:0] : 5'd0;
      pend_d  = rd_en_q;
      if (accept)
         blk_d = oob;
      else if (state_q == CHECK)
         blk_d = blk_q | (pend_q & rd_occ) | (probe & oob);
      else
         blk_d = blk_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         k_q           <= 2'd0;
         cand_x_q      <= 6'sd0;
         cand_y_q      <= 6'sd0;
         cand_rot_q    <= 2'd0;
         cand_shape_q  <= 3'd0;
         is_spawn_q    <= 1'b0;
         is_down_q     <= 1'b0;
         inv_q         <= 1'b0;
         blk_q         <= 1'b0;
         pend_q        <= 1'b0;
         cmd_ready_q   <= 1'b0;
         rd_en_q       <= 1'b0;
         rd_x_q        <= 4'd0;
         rd_y_q        <= 5'd0;
         piece_valid_q <= 1'b0;
         piece_x_q     <= 4'd0;
         piece_y_q     <= 5'd0;
         piece_rot_q   <= 2'd0;
         piece_shape_q <= 3'd0;
         done_q        <= 1'b0;
         blocked_q     <= 1'b0;
         lock_q        <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         cand_x_q      <= cand_x_d;
         cand_y_q      <= cand_y_d;
         cand_rot_q    <= cand_rot_d;
         cand_shape_q  <= cand_shape_d;
         is_spawn_q    <= is_spawn_d;
         is_down_q     <= is_down_d;
         inv_q         <= inv_d;
         blk_q         <= blk_d;
         pend_q        <= pend_d;
         cmd_ready_q   <= cmd_ready_d;
         rd_en_q       <= rd_en_d;
         rd_x_q        <= rd_x_d;
         rd_y_q        <= rd_y_d;
         piece_valid_q <= piece_valid_d;
         piece_x_q     <= piece_x_d;
         piece_y_q     <= piece_y_d;
         piece_rot_q   <= piece_rot_d;
         piece_shape_q <= piece_shape_d;
         done_q        <= done_d;
         blocked_q     <= blocked_d;
         lock_q        <= lock_d;
         game_over_q   <= game_over_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rd_en       = rd_en_q;
   assign rd_x        = rd_x_q;
   assign rd_y        = rd_y_q;
   assign piece_valid = piece_valid_q;
   assign piece_x     = piece_x_q;
   assign piece_y     = piece_y_q;
   assign piece_rot   = piece_rot_q;
   assign piece_shape = piece_shape_q;
   assign done        = done_q;
   assign blocked     = blocked_q;
   assign lock        = lock_q;
   assign game_over   = game_over_q;

endmodule
